// File: rtl/lif_neuron_update_if.sv
// Bundle of the sweep control, input and report signals of the LIF update stage.
// The master side drives the i_* signals; the slave (the neuron stage) drives o_*.
interface lif_neuron_update_if #(
    parameter int N_NEURON = 18,
    parameter int IDX_W    = 5,
    parameter int CUR_W    = 16
);
    logic                      i_start;
    logic                      i_s_init;
    logic [N_NEURON*CUR_W-1:0] i_current;
    logic [4:0]                i_inhbt;
    logic                      o_valid;
    logic                      o_spike;
    logic [IDX_W-1:0]          o_neuron_idx;
    logic                      o_s_init;
    logic                      o_cnt_clr;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_start, i_s_init, i_current, i_inhbt,
        input  o_valid, o_spike, o_neuron_idx, o_s_init, o_cnt_clr, o_busy, o_done
    );

    modport slave (
        input  i_start, i_s_init, i_current, i_inhbt,
        output o_valid, o_spike, o_neuron_idx, o_s_init, o_cnt_clr, o_busy, o_done
    );
endinterface

// File: rtl/lif_neuron_update.sv
// Serial leaky-integrate-and-fire membrane update: one neuron per cycle per timestep,
// with an index-tagged state-clear sweep at sample start. All outputs are registered.
module lif_neuron_update #(
    parameter int              N_NEURON    = 18,
    parameter int              IDX_W       = 5,
    parameter int              V_W         = 16,
    parameter int              CUR_W       = 16,
    parameter logic [V_W-1:0]  THRESH      = 16'd1000,
    parameter int              LEAK_SHIFT  = 4,
    parameter int              INHBT_SHIFT = 6,
    parameter int              REFRAC      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    lif_neuron_update_if.slave    bus
);
    localparam int SW   = V_W + 3;
    localparam int RF_W = $clog2(REFRAC + 1);
    localparam logic signed [SW-1:0] V_MAX_S = {3'b000, {V_W{1'b1}}};
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_NEURON - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             queued_q, queued_d;
    logic [4:0]       inhbt_q, inhbt_d;

    logic [V_W-1:0]   v_q      [N_NEURON];
    logic [RF_W-1:0]  refrac_q [N_NEURON];

    logic             wr_en_d;
    logic [V_W-1:0]   v_wr_d;
    logic [RF_W-1:0]  refrac_wr_d;

    logic             valid_q, valid_d;
    logic             spike_q, spike_d;
    logic [IDX_W-1:0] nidx_q, nidx_d;
    logic             s_init_q, s_init_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [V_W-1:0]          v_cur_s;
    logic [RF_W-1:0]         rf_cur_s;
    logic [CUR_W-1:0]        cur_s;
    logic signed [SW-1:0]    sum_s;
    logic [V_W-1:0]          v_next_s;

    // Membrane arithmetic for the neuron currently addressed by idx_q.
    always_comb begin
        v_cur_s  = v_q[idx_q];
        rf_cur_s = refrac_q[idx_q];
        cur_s    = bus.i_current[32'(idx_q) * CUR_W +: CUR_W];
        sum_s    = signed'(SW'(v_cur_s)) - signed'(SW'(v_cur_s >> LEAK_SHIFT))
                 + signed'(SW'(cur_s)) - signed'(SW'(inhbt_q) << INHBT_SHIFT);
        if (sum_s < signed'(SW'(0))) begin
            v_next_s = '0;
        end else if (sum_s > V_MAX_S) begin
            v_next_s = {V_W{1'b1}};
        end else begin
            v_next_s = sum_s[V_W-1:0];
        end
    end

    // Sweep sequencing, per-neuron update decision and next output values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        queued_d    = queued_q;
        inhbt_d     = inhbt_q;
        wr_en_d     = 1'b0;
        v_wr_d      = '0;
        refrac_wr_d = '0;
        valid_d     = 1'b0;
        spike_d     = 1'b0;
        nidx_d      = '0;
        s_init_d    = 1'b0;
        cnt_clr_d   = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.i_s_init) begin
                    state_d  = ST_INIT;
                    queued_d = bus.i_start;
                end else if (bus.i_start) begin
                    state_d = ST_RUN;
                    inhbt_d = bus.i_inhbt;
                end else begin
                    queued_d = 1'b0;
                end
            end
            ST_INIT: begin
                s_init_d  = 1'b1;
                nidx_d    = idx_q;
                cnt_clr_d = (idx_q == '0);
                wr_en_d   = 1'b1;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    queued_d = 1'b0;
                    if (queued_q) begin
                        state_d = ST_RUN;
                        inhbt_d = bus.i_inhbt;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                valid_d = 1'b1;
                nidx_d  = idx_q;
                wr_en_d = 1'b1;
                if (rf_cur_s != '0) begin
                    refrac_wr_d = rf_cur_s - RF_W'(1);
                end else if (v_next_s >= THRESH) begin
                    spike_d     = 1'b1;
                    refrac_wr_d = RF_W'(REFRAC);
                end else begin
                    v_wr_d = v_next_s;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Busy spans the state occupancy plus the one-cycle output lag.
        busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            queued_q  <= 1'b0;
            inhbt_q   <= '0;
            valid_q   <= 1'b0;
            spike_q   <= 1'b0;
            nidx_q    <= '0;
            s_init_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            queued_q  <= queued_d;
            inhbt_q   <= inhbt_d;
            valid_q   <= valid_d;
            spike_q   <= spike_d;
            nidx_q    <= nidx_d;
            s_init_q  <= s_init_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Per-neuron membrane and refractory storage, written one neuron per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_NEURON; k++) begin
                v_q[k]      <= '0;
                refrac_q[k] <= '0;
            end
        end else if (wr_en_d) begin
            v_q[idx_q]      <= v_wr_d;
            refrac_q[idx_q] <= refrac_wr_d;
        end
    end

    assign bus.o_valid      = valid_q;
    assign bus.o_spike      = spike_q;
    assign bus.o_neuron_idx = nidx_q;
    assign bus.o_s_init     = s_init_q;
    assign bus.o_cnt_clr    = cnt_clr_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
endmodule

// File: tb/tb_lif_neuron_update.sv
// Scoreboard bench for lif_neuron_update: stimulus pushes cycle-stamped expected
// reports from an arithmetic LIF model; a negedge monitor pops and compares.
module tb_lif_neuron_update;
    localparam int N = 18;

    typedef struct {
        int cyc;
        bit valid;
        bit s_init;
        bit cnt_clr;
        bit done;
        int idx;
        bit spike;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    exp_t q[$];

    int   v_m [N];
    int   rf_m [N];
    int   cur_m [N];
    int   inhbt_val = 0;

    lif_neuron_update_if #(.N_NEURON(N), .IDX_W(5), .CUR_W(16)) bus ();

    lif_neuron_update dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drive the packed current bus from the per-neuron table.
    always_comb begin
        for (int k = 0; k < N; k++) bus.i_current[k*16 +: 16] = cur_m[k][15:0];
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_init(input int t);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            v_m[k] = 0;
            rf_m[k] = 0;
            e = '{cyc: t + 2 + k, valid: 1'b0, s_init: 1'b1, cnt_clr: (k == 0),
                  done: 1'b0, idx: k, spike: 1'b0};
            q.push_back(e);
        end
    endtask

    task automatic model_run(input int base, input int inh);
        exp_t e;
        int   s;
        bit   sp;
        for (int k = 0; k < N; k++) begin
            sp = 1'b0;
            if (rf_m[k] > 0) begin
                rf_m[k] = rf_m[k] - 1;
                v_m[k] = 0;
            end else begin
                s = v_m[k] - (v_m[k] / 16) + cur_m[k] - inh * 64;
                if (s < 0) s = 0;
                if (s > 65535) s = 65535;
                if (s >= 1000) begin
                    sp = 1'b1;
                    v_m[k] = 0;
                    rf_m[k] = 3;
                end else begin
                    v_m[k] = s;
                end
            end
            e = '{cyc: base + 2 + k, valid: 1'b1, s_init: 1'b0, cnt_clr: 1'b0,
                  done: 1'b0, idx: k, spike: sp};
            q.push_back(e);
        end
        e = '{cyc: base + 20, valid: 1'b0, s_init: 1'b0, cnt_clr: 1'b0,
              done: 1'b1, idx: 0, spike: 1'b0};
        q.push_back(e);
    endtask

    // Issue one request in the current cycle; optionally disturb the bus mid-sweep.
    task automatic issue(input bit do_init, input bit do_start, input bit poke);
        int t;
        t = cyc;
        bus.i_s_init = do_init;
        bus.i_start  = do_start;
        bus.i_inhbt  = 5'(inhbt_val);
        if (do_init) model_init(t);
        if (do_start) model_run(do_init ? t + 18 : t, inhbt_val);
        busy_lo = t + 1;
        busy_hi = do_start ? (do_init ? t + 38 : t + 20) : t + 19;
        step();
        bus.i_s_init = 1'b0;
        bus.i_start  = 1'b0;
        if (poke) begin
            repeat ((do_init && do_start) ? 23 : 5) step();
            bus.i_start  = 1'b1;
            bus.i_s_init = 1'($urandom_range(0, 1));
            bus.i_inhbt  = 5'($urandom_range(0, 31));
            step();
            bus.i_start  = 1'b0;
            bus.i_s_init = 1'b0;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && cyc > busy_hi) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d required=0", q.size());
        end
        step();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({bus.o_valid, bus.o_spike, bus.o_neuron_idx, bus.o_s_init, bus.o_cnt_clr,
             bus.o_busy, bus.o_done} !== '0) begin
            errors++;
            $display("FAIL %s: outputs v=%b sp=%b idx=%0d si=%b clr=%b busy=%b done=%b required all 0",
                     name, bus.o_valid, bus.o_spike, bus.o_neuron_idx, bus.o_s_init,
                     bus.o_cnt_clr, bus.o_busy, bus.o_done);
        end
    endtask

    // Monitor: busy window, exclusivity, missing and unexpected reports, report contents.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_busy;
        if (mon_en) begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (bus.o_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: cyc=%0d got=%b required=%b", cyc, bus.o_busy, exp_busy);
            end
            checks++;
            if (bus.o_valid === 1'b1 && bus.o_s_init === 1'b1) begin
                errors++;
                $display("FAIL exclusive: cyc=%0d valid and s_init both 1, required not both", cyc);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing: report for cyc=%0d idx=%0d never appeared", e.cyc, e.idx);
            end
            if (bus.o_valid || bus.o_s_init || bus.o_done || bus.o_cnt_clr) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: cyc=%0d v=%b si=%b done=%b clr=%b idx=%0d, required no report",
                             cyc, bus.o_valid, bus.o_s_init, bus.o_done, bus.o_cnt_clr, bus.o_neuron_idx);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || bus.o_valid !== e.valid || bus.o_s_init !== e.s_init ||
                        bus.o_cnt_clr !== e.cnt_clr || bus.o_done !== e.done ||
                        bus.o_spike !== e.spike ||
                        ((e.valid || e.s_init) && int'(bus.o_neuron_idx) != e.idx)) begin
                        errors++;
                        $display("FAIL report: got cyc=%0d v=%b si=%b clr=%b done=%b idx=%0d sp=%b required cyc=%0d v=%b si=%b clr=%b done=%b idx=%0d sp=%b",
                                 cyc, bus.o_valid, bus.o_s_init, bus.o_cnt_clr, bus.o_done,
                                 bus.o_neuron_idx, bus.o_spike, e.cyc, e.valid, e.s_init,
                                 e.cnt_clr, e.done, e.idx, e.spike);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        bus.i_start  = 1'b0;
        bus.i_s_init = 1'b0;
        bus.i_inhbt  = 5'd0;
        for (int k = 0; k < N; k++) begin
            cur_m[k] = 0;
            v_m[k] = 0;
            rf_m[k] = 0;
        end
        repeat (3) step();
        reset = 1'b0;
        check_idle_outputs("reset_state");
        mon_en = 1'b1;
        step();

        // All-zero currents: 18 silent reports then done.
        issue(1'b0, 1'b1, 1'b0);
        drain();

        // Neuron 5 integrates 600 per step; a busy-time start is ignored.
        cur_m[5] = 600;
        issue(1'b0, 1'b1, 1'b1);
        drain();
        issue(1'b0, 1'b1, 1'b0);
        drain();

        // Refractory window with a strong drive.
        cur_m[5] = 1200;
        for (int s = 0; s < 5; s++) begin
            issue(1'b0, 1'b1, 1'b0);
            drain();
        end

        // Snapshotted inhibition, changed mid-RUN after a combined init+start.
        for (int k = 0; k < N; k++) cur_m[k] = 0;
        cur_m[0] = 2000;
        inhbt_val = 20;
        issue(1'b1, 1'b1, 1'b1);
        drain();

        // Saturation then negative clamp.
        inhbt_val = 0;
        for (int k = 0; k < N; k++) cur_m[k] = 900;
        issue(1'b1, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < N; k++) cur_m[k] = 65535;
        issue(1'b0, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < N; k++) cur_m[k] = 900;
        issue(1'b1, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < N; k++) cur_m[k] = 0;
        inhbt_val = 31;
        issue(1'b0, 1'b1, 1'b0);
        drain();
        for (int k = 0; k < N; k++) cur_m[k] = 999;
        inhbt_val = 0;
        issue(1'b0, 1'b1, 1'b0);
        drain();

        // Init-only sweep (no done).
        issue(1'b1, 1'b0, 1'b0);
        drain();

        // Randomised sweeps.
        for (int s = 0; s < 30; s++) begin
            int mode;
            for (int k = 0; k < N; k++)
                cur_m[k] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535))
                                                       : int'($urandom_range(0, 700));
            inhbt_val = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31))
                                                    : int'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            issue(mode == 1 || mode == 2, mode != 1, 1'($urandom_range(0, 1)));
            drain();
        end

        // Reset in the middle of a RUN sweep.
        for (int k = 0; k < N; k++) cur_m[k] = 1500;
        issue(1'b0, 1'b1, 1'b0);
        repeat (7) step();
        r = cyc;
        reset = 1'b1;
        while (q.size() > 0 && q[$].cyc > r) void'(q.pop_back());
        busy_hi = r;
        for (int k = 0; k < N; k++) begin
            v_m[k] = 0;
            rf_m[k] = 0;
        end
        step();
        reset = 1'b0;
        check_idle_outputs("reset_mid_run");
        repeat (25) step();
        drain();

        // State after reset is cleared: a fresh sweep behaves from v=0.
        issue(1'b0, 1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
